// File: rtl/tmds_std_dec_if.sv
// TMDS decoder channel bundle: raw deserialized word in, decoded symbol fields out.
// Latency: n/a (signal grouping only).
// Backpressure: none; one word per clock in and out.
interface tmds_std_dec_if;
    logic [9:0] din;
    logic       de;
    logic       c0;
    logic       c1;
    logic [7:0] dout;
    logic       locked;
    logic [3:0] offset;

    modport master (
        output din,
        input  de, c0, c1, dout, locked, offset
    );

    modport slave (
        input  din,
        output de, c0, c1, dout, locked, offset
    );
endinterface

// File: rtl/tmds_std_dec.sv
// Single-channel TMDS decoder: bit-slip word alignment by control-token search, then symbol decode.
// Latency: a word captured on edge N is decoded onto the outputs at edge N+2.
// Backpressure: none; accepts and emits one word every clock.
module tmds_std_dec #(
    parameter int LOCK_TOKENS   = 16,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_WINDOW   = 4096
) (
    input  logic          clk,
    input  logic          reset,
    tmds_std_dec_if.slave bus
);
    localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
    localparam int WIN_W  = $clog2(SEARCH_WINDOW);
    localparam int MISS_W = $clog2(LOSS_WINDOW);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_WINDOW - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state;
    logic [9:0]        cur;
    logic [9:0]        prev;
    logic [RUN_W-1:0]  tok_run;
    logic [WIN_W-1:0]  win_cnt;
    logic [MISS_W-1:0] miss_cnt;

    logic [19:0] window;
    logic [9:0]  q;
    logic        is_tok;
    logic [1:0]  tok_c;
    logic [8:0]  t;
    logic [7:0]  d;
    logic [3:0]  next_offset;

    assign window      = {cur, prev};
    assign next_offset = (bus.offset == 4'd9) ? 4'd0 : bus.offset + 4'd1;

    // prev holds the earlier word, so offset k takes the last 10-k bits of prev then k bits of cur
    always_comb begin
        q = window[9:0];
        for (int k = 1; k < 10; k++) begin
            if (bus.offset == 4'(k)) begin
                q = window[k +: 10];
            end
        end
    end

    always_comb begin
        is_tok = 1'b1;
        tok_c  = 2'b00;
        case (q)
            10'h354: tok_c = 2'b00;
            10'h0AB: tok_c = 2'b01;
            10'h154: tok_c = 2'b10;
            10'h2AB: tok_c = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    always_comb begin
        t    = {q[8], q[9] ? ~q[7:0] : q[7:0]};
        d    = 8'h00;
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = t[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            cur        <= '0;
            prev       <= '0;
            tok_run    <= '0;
            win_cnt    <= '0;
            miss_cnt   <= '0;
            bus.offset <= 4'd0;
            bus.locked <= 1'b0;
            bus.de     <= 1'b0;
            bus.c0     <= 1'b0;
            bus.c1     <= 1'b0;
            bus.dout   <= 8'h00;
        end else begin
            prev <= cur;
            cur  <= bus.din;
            case (state)
                SEARCH: begin
                    bus.de   <= 1'b0;
                    bus.c0   <= 1'b0;
                    bus.c1   <= 1'b0;
                    bus.dout <= 8'h00;
                    // a completed token run wins over a window expiry on the same edge
                    if (is_tok && tok_run == RUN_LAST) begin
                        state      <= LOCKED;
                        bus.locked <= 1'b1;
                        tok_run    <= '0;
                        win_cnt    <= '0;
                        miss_cnt   <= '0;
                    end else if (win_cnt == WIN_LAST) begin
                        bus.offset <= next_offset;
                        tok_run    <= '0;
                        win_cnt    <= '0;
                    end else begin
                        tok_run <= is_tok ? tok_run + 1'b1 : '0;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (is_tok) begin
                        miss_cnt <= '0;
                        bus.de   <= 1'b0;
                        bus.c0   <= tok_c[0];
                        bus.c1   <= tok_c[1];
                        bus.dout <= 8'h00;
                    end else if (miss_cnt == MISS_LAST) begin
                        state      <= SEARCH;
                        bus.locked <= 1'b0;
                        bus.offset <= next_offset;
                        tok_run    <= '0;
                        win_cnt    <= '0;
                        miss_cnt   <= '0;
                        bus.de     <= 1'b0;
                        bus.c0     <= 1'b0;
                        bus.c1     <= 1'b0;
                        bus.dout   <= 8'h00;
                    end else begin
                        miss_cnt <= miss_cnt + 1'b1;
                        bus.de   <= 1'b1;
                        bus.dout <= d;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_tmds_std_dec.sv
// Randomized bench for tmds_std_dec: bit-level stream model plus a reference TMDS encoder.
module tb_tmds_std_dec;
    localparam int LOCK_TOKENS   = 16;
    localparam int SEARCH_WINDOW = 2048;
    localparam int LOSS_WINDOW   = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    tmds_std_dec_if bus ();

    tmds_std_dec #(
        .LOCK_TOKENS  (LOCK_TOKENS),
        .SEARCH_WINDOW(SEARCH_WINDOW),
        .LOSS_WINDOW  (LOSS_WINDOW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    int tok_word [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    // reference state: the word history, the chosen offset and lock bookkeeping
    int m_cur, m_prev, m_off, m_run, m_win, m_miss;
    bit m_lk;
    int e_de, e_c0, e_c1, e_dout;

    int enc_cnt;
    bit bitq [$];
    int sym_ctrl [$];
    int sym_val  [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tb_tok(input int q);
        for (int c = 0; c < 4; c++) begin
            if (q == tok_word[c]) return c;
        end
        return -1;
    endfunction

    function automatic int tb_decode(input int q);
        int t, r, x;
        t = q & 'h1FF;
        if ((q & 'h200) != 0) t = t ^ 'hFF;
        r = t & 1;
        for (int i = 1; i < 8; i++) begin
            x = ((t >> i) & 1) ^ ((t >> (i - 1)) & 1);
            if (((t >> 8) & 1) == 0) x = x ^ 1;
            r = r | (x << i);
        end
        return r;
    endfunction

    function automatic logic [9:0] tmds_enc(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
        end
        return q;
    endfunction

    task automatic model_step(input int w, input bit r);
        int q, c;
        if (r) begin
            m_cur = 0; m_prev = 0; m_off = 0; m_lk = 0;
            m_run = 0; m_win = 0; m_miss = 0;
            e_de = 0; e_c0 = 0; e_c1 = 0; e_dout = 0;
        end else begin
            q = ((((m_cur << 10) | m_prev) >> m_off) & 'h3FF);
            c = tb_tok(q);
            if (!m_lk) begin
                e_de = 0; e_c0 = 0; e_c1 = 0; e_dout = 0;
                m_run = (c >= 0) ? m_run + 1 : 0;
                m_win++;
                if (m_run == LOCK_TOKENS) begin
                    m_lk = 1; m_run = 0; m_win = 0; m_miss = 0;
                end else if (m_win == SEARCH_WINDOW) begin
                    m_off = (m_off + 1) % 10; m_run = 0; m_win = 0;
                end
            end else if (c >= 0) begin
                m_miss = 0;
                e_de = 0; e_c0 = c & 1; e_c1 = (c >> 1) & 1; e_dout = 0;
            end else begin
                m_miss++;
                if (m_miss == LOSS_WINDOW) begin
                    m_lk = 0; m_off = (m_off + 1) % 10;
                    m_run = 0; m_win = 0; m_miss = 0;
                    e_de = 0; e_c0 = 0; e_c1 = 0; e_dout = 0;
                end else begin
                    e_de = 1; e_dout = tb_decode(q);
                end
            end
            m_prev = m_cur;
            m_cur  = w;
        end
    endtask

    task automatic tick(input logic [9:0] w, input bit r);
        bus.din = w;
        reset   = r;
        @(posedge clk);
        model_step(int'(w), r);
        chk_en = 1'b1;
        #1;
    endtask

    task automatic push_sym(input int is_ctrl, input int val);
        logic [9:0] word;
        if (is_ctrl != 0) begin
            word = 10'(tok_word[val]);
            enc_cnt = 0;
        end else begin
            word = tmds_enc(8'(val));
            chk("enc_roundtrip", tb_decode(int'(word)), val);
        end
        sym_ctrl.push_back(is_ctrl);
        sym_val.push_back(val);
        for (int b = 0; b < 10; b++) bitq.push_back(word[b]);
    endtask

    task automatic gen_period();
        int c;
        c = $urandom_range(3);
        for (int i = 0; i < 40; i++) push_sym(1, c);
        for (int i = 0; i < 100; i++) push_sym(0, $urandom_range(255));
    endtask

    initial begin
        logic [16:0] act, exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                act = {bus.locked, bus.offset, bus.de, bus.c1, bus.c0, bus.dout};
                exp = {m_lk, 4'(m_off), 1'(e_de), 1'(e_c1), 1'(e_c0), 8'(e_dout)};
                chk("cycle_outputs", int'(act), int'(exp));
            end
        end
    end

    initial begin
        logic [9:0] w;
        int lock_at, idx;
        bit prev_lk;

        chk("pin_dec_100", tb_decode('h100), 'h00);
        chk("pin_dec_2FF", tb_decode('h2FF), 'hFE);

        // aligned stream locks on the edge after the 16th token reaches the window
        tick(10'h000, 1'b1);
        chk("rst_outputs", {bus.locked, bus.offset, bus.de, bus.c1, bus.c0, bus.dout}, 0);
        for (int i = 1; i <= 20; i++) begin
            tick(10'h354, 1'b0);
            if (i == 17) chk("t1_not_yet_locked", bus.locked, 0);
            if (i == 18) chk("t1_locked", bus.locked, 1);
        end
        tick(10'h100, 1'b0);
        tick(10'h354, 1'b0);
        tick(10'h354, 1'b0);
        chk("t1_data", {bus.de, bus.c1, bus.c0, bus.dout, bus.offset}, {1'b1, 2'b00, 8'h00, 4'd0});

        tick(10'h0AB, 1'b0);
        tick(10'h2AB, 1'b0);
        tick(10'h2FF, 1'b0);
        chk("t2_tok_0AB", {bus.de, bus.c1, bus.c0, bus.dout}, {1'b0, 2'b01, 8'h00});
        tick(10'h354, 1'b0);
        chk("t2_tok_2AB", {bus.de, bus.c1, bus.c0}, {1'b0, 2'b11});
        tick(10'h354, 1'b0);
        chk("t2_data_hold", {bus.de, bus.c1, bus.c0, bus.dout}, {1'b1, 2'b11, 8'hFE});

        // loss of lock after LOSS_WINDOW consecutive data words
        for (int i = 1; i <= LOSS_WINDOW + 2; i++) begin
            tick(10'h100, 1'b0);
            if (i == LOSS_WINDOW + 1) chk("t4_still_locked", bus.locked, 1);
        end
        chk("t4_lost", {bus.locked, bus.offset, bus.de, bus.c1, bus.c0, bus.dout}, {1'b0, 4'd1, 11'd0});

        // reset in the middle of a locked data stream
        tick(10'h000, 1'b1);
        for (int i = 0; i < 20; i++) tick(10'h354, 1'b0);
        for (int i = 0; i < 5; i++) tick(10'($urandom_range(1023)) | 10'h100, 1'b0);
        tick(10'h354, 1'b1);
        chk("t6_reset", {bus.locked, bus.offset, bus.de, bus.c1, bus.c0, bus.dout}, 0);
        for (int i = 1; i <= 18; i++) begin
            tick(10'h354, 1'b0);
            if (i == 17) chk("t6_relock_pending", bus.locked, 0);
        end
        chk("t6_relocked", bus.locked, 1);

        // stream rotated so alignment sits at offset 3
        tick(10'h000, 1'b1);
        enc_cnt = 0;
        bitq.delete();
        sym_ctrl.delete();
        sym_val.delete();
        gen_period();
        for (int b = 0; b < 7; b++) void'(bitq.pop_front());
        lock_at = -1;
        prev_lk = 1'b0;
        for (int k = 1; k <= 9000; k++) begin
            while (bitq.size() < 10) gen_period();
            for (int b = 0; b < 10; b++) w[b] = bitq.pop_front();
            tick(w, 1'b0);
            if (k == 2047) chk("t3_off_w0", bus.offset, 0);
            if (k == 2048 || k == 4096 || k == 6144) chk("t3_off_step", bus.offset, k / 2048);
            if (lock_at < 0 && bus.locked) lock_at = k;
            if (prev_lk && m_lk) begin
                idx = k - 2;
                if (sym_ctrl[idx] != 0)
                    chk("t3_ctrl", {bus.de, bus.c1, bus.c0}, {1'b0, 2'(sym_val[idx])});
                else
                    chk("t3_pixel", {bus.de, bus.dout}, {1'b1, 8'(sym_val[idx])});
            end
            prev_lk = m_lk;
        end
        chk("t3_lock_in_4th_window", int'(lock_at > 3 * SEARCH_WINDOW && lock_at <= 4 * SEARCH_WINDOW), 1);
        chk("t3_offset", bus.offset, 3);

        // offset wraps from 9 back to 0
        tick(10'h000, 1'b1);
        for (int i = 1; i <= 10 * SEARCH_WINDOW; i++) begin
            tick(10'h100, 1'b0);
            if (i == 9 * SEARCH_WINDOW - 1) chk("t5_off8", bus.offset, 8);
            if (i == 9 * SEARCH_WINDOW) chk("t5_off9", bus.offset, 9);
            if (i == 10 * SEARCH_WINDOW - 1) chk("t5_off9_hold", bus.offset, 9);
        end
        chk("t5_wrap", {bus.locked, bus.offset}, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
